prog_clk_divider: RTL and testbench

Runtime-programmable integer clock divider. It is the parametrised successor to the team's fixed divide-by-2 toggle block. It produces a divided clock-level signal `clk_out` with near-50% duty, plus a one-cycle `tick` enable pulse at each period start, for any divisor 1..2^WIDTH-1. The divisor is reloaded glitch-free at period boundaries, and a `sync` input realigns the phase. It sits between the system clock and downstream rate-enabled logic (UART baud, LED scan, sampling strobes).

---
 rtl/prog_clk_divider.sv | 86 ++++++++
 tb/tb_prog_clk_divider.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider: near-50% clk_out level plus a
// one-cycle tick at each period start; divisor swaps only at period boundaries.
module prog_clk_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_act,
  output logic             pending,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_pend, div_pend_nxt, div_act_nxt;
  logic [WIDTH:0]   half, cnt_inc;
  logic             wrap, load_ok, load_bad;
  logic             pend_nxt, clk_nxt, tick_nxt;

  always_comb begin
    load_ok  = div_load && (div_in != '0);
    load_bad = div_load && (div_in == '0);
    // div_act is never zero, so div_act-1 cannot underflow and cnt stays below it
    wrap     = en && (sync || (cnt == div_act - ONE));
    // one extra bit keeps ceil(N/2) and cnt+1 exact at N = 2^WIDTH-1
    half     = ({1'b0, div_act} + ONE_X) >> 1;
    cnt_inc  = {1'b0, cnt} + ONE_X;

    cnt_nxt      = cnt;
    clk_nxt      = clk_out;
    tick_nxt     = 1'b0;
    div_act_nxt  = div_act;
    div_pend_nxt = div_pend;
    pend_nxt     = pending;

    if (wrap) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
      clk_nxt  = 1'b1;
      pend_nxt = 1'b0;
      // a load landing on the boundary edge beats an older pending value
      if (load_ok)      div_act_nxt = div_in;
      else if (pending) div_act_nxt = div_pend;
    end else begin
      if (en) begin
        cnt_nxt = cnt_inc[WIDTH-1:0];
        clk_nxt = (cnt_inc < half);
      end
      if (load_ok) begin
        div_pend_nxt = div_in;
        pend_nxt     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= DEF_DIV - ONE;
      div_act  <= DEF_DIV;
      div_pend <= '0;
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      div_act  <= div_act_nxt;
      div_pend <= div_pend_nxt;
      pending  <= pend_nxt;
      clk_out  <= clk_nxt;
      tick     <= tick_nxt;
      load_err <= load_bad;
    end
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomized + directed bench for prog_clk_divider against a period-position model.
module tb_prog_clk_divider;

  localparam int W   = 8;
  localparam int DEF = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, div_load, sync;
  logic [W-1:0] div_in;
  logic         clk_out, tick, pending, load_err;
  logic [W-1:0] div_act;

  prog_clk_divider #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .sync(sync), .clk_out(clk_out), .tick(tick), .div_act(div_act),
    .pending(pending), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model: position within the current period, period length, queued divisor
  int m_pos, m_n, m_pendv;
  bit m_pend, m_clk, m_tick, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pos = DEF - 1; m_n = DEF; m_pend = 0; m_pendv = 0;
    m_clk = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit e, input bit s, input bit l, input int d);
    bit boundary;
    m_err    = l && (d == 0);
    boundary = e && (s || (m_pos + 1 == m_n));
    if (boundary) begin
      m_pos  = 0;
      m_tick = 1;
      m_clk  = 1;
      if (l && d != 0) m_n = d;
      else if (m_pend) m_n = m_pendv;
      m_pend = 0;
    end else begin
      m_tick = 0;
      if (e) begin
        m_pos = m_pos + 1;
        m_clk = (m_pos < (m_n + 1) / 2);
      end
      if (l && d != 0) begin
        m_pend  = 1;
        m_pendv = d;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".tick"},     tick,     m_tick);
    chk({ph, ".clk_out"},  clk_out,  m_clk);
    chk({ph, ".div_act"},  div_act,  m_n);
    chk({ph, ".pending"},  pending,  m_pend);
    chk({ph, ".load_err"}, load_err, m_err);
  endtask

  task automatic step(input string ph, input bit e, input bit s, input bit l, input int d);
    en = e; sync = s; div_load = l; div_in = d[W-1:0];
    @(posedge clk);
    model_edge(e, s, l, d);
    #1;
    check_all(ph);
  endtask

  task automatic run(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 1, 0, 0, 0);
  endtask

  // advance with en=1 until the model reaches position p (bounded)
  task automatic run_to_pos(input string ph, input int p);
    int k;
    k = 0;
    while (m_pos != p && k < 600) begin
      step(ph, 1, 0, 0, 0);
      k++;
    end
    if (m_pos != p) chk({ph, ".reach_pos"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 0; sync = 0; div_load = 0; div_in = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); rst = 1'b1;

    // default divide-by-2: first enabled edge is a period start
    run("div2", 6);

    // load 5 mid-period, then watch it take over at the boundary
    step("load5", 1, 0, 1, 5);
    run("div5", 12);

    // zero divisor is rejected
    step("load0", 1, 0, 1, 0);
    run("after0", 6);

    // last of two loads within a period wins (N=6)
    step("load6", 1, 0, 1, 6);
    run_to_pos("to_start6", 0);
    step("load4", 1, 0, 1, 4);
    step("load7", 1, 0, 1, 7);
    run("div7", 16);

    // load coincident with a wrap takes effect immediately
    run_to_pos("to_wrap", m_n - 1);
    step("load3_wrap", 1, 0, 1, 3);
    run("div3", 7);

    // divide-by-1, then freeze with en=0 and resume
    step("load1", 1, 0, 1, 1);
    run("div1", 5);
    for (int i = 0; i < 4; i++) step("en_off", 0, 0, 0, 0);
    run("resume1", 3);

    // freeze mid-period at N=5
    step("load5b", 1, 0, 1, 5);
    run_to_pos("to_pos2", 2);
    for (int i = 0; i < 4; i++) step("en_off5", 0, 0, 0, 0);
    run("resume5", 6);

    // sync at cnt=3 with N=8; sync while disabled is ignored
    step("load8", 1, 0, 1, 8);
    run_to_pos("to_pos3", 3);
    step("sync", 1, 1, 0, 0);
    step("sync_off", 0, 1, 0, 0);
    run("after_sync", 10);

    // asynchronous reset mid-period
    run_to_pos("to_pos5", 5);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk); rst = 1'b1;
    run("post_rst", 4);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit e, s, l;
      int d;
      e = ($urandom % 8) != 0;
      s = ($urandom % 40) == 0;
      l = ($urandom % 6) == 0;
      d = (($urandom % 10) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      step("rand", e, s, l, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
